// File: rtl/x_wb_arbiter.sv
// ============================================================================
// Module   : x_wb_arbiter
// Purpose  : Scalar X register-file write arbiter. The scalar pipeline
//            writeback (port A) takes priority. Vector-unit scalar results
//            (port B) are queued in a FIFO, and an anti-starvation stall
//            lets the FIFO head through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        stg_stall,
  output logic        reg_w,
  output logic [4:0]  rd,
  output logic [31:0] w_data,
  output logic [31:0] pend_mask,
  output logic        err_waw
);

  localparam int              c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
  localparam logic [7:0]      c_LIMIT = 8'(STARVE_LIMIT);

  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [7:0]       r_starve;
  logic [DEPTH-1:0] r_vld;
  logic [4:0]       r_mem_rd   [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];

  logic        w_nonempty;
  logic        w_push;
  logic        w_store;
  logic        w_pop;
  logic        w_a_win;
  logic        w_waw;
  logic [31:0] w_pend;
  logic [31:0] w_slot_mask [DEPTH];

  assign w_nonempty = (r_count != '0);
  // Readiness depends on occupancy alone, so a full FIFO never passes a
  // push straight through on the cycle it pops.
  assign b_ready    = !rst && (r_count < c_DEPTH);
  assign stg_stall  = !rst && w_nonempty && (r_starve == c_LIMIT);

  assign w_push  = b_valid && b_ready;
  assign w_store = w_push && (b_rd != 5'd0);
  assign w_pop   = !rst && w_nonempty && (stg_stall || !a_valid);
  assign w_a_win = !rst && a_valid && !stg_stall;
  assign w_waw   = w_a_win && (a_rd != 5'd0) && pend_mask[a_rd];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_slot_mask[gi] = r_vld[gi] ? (32'd1 << r_mem_rd[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend = w_pend | w_slot_mask[i];
    end
    pend_mask = {w_pend[31:1], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_store) begin
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_vld[r_wr_ptr] <= 1'b1;
      end
      r_count <= r_count + c_CW'(w_store) - c_CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_rd[r_wr_ptr]   <= b_rd;
      r_mem_data[r_wr_ptr] <= b_data;
    end
  end

  // A port-A write to x0 still consumes the slot but never reaches the file.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_w  <= 1'b0;
      rd     <= '0;
      w_data <= '0;
    end else if (w_pop) begin
      reg_w  <= 1'b1;
      rd     <= r_mem_rd[r_rd_ptr];
      w_data <= r_mem_data[r_rd_ptr];
    end else if (w_a_win && (a_rd != 5'd0)) begin
      reg_w  <= 1'b1;
      rd     <= a_rd;
      w_data <= a_data;
    end else begin
      reg_w  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      err_waw  <= 1'b0;
    end else begin
      if (w_pop || !w_nonempty) begin
        r_starve <= '0;
      end else if (w_a_win && (r_starve != c_LIMIT)) begin
        r_starve <= r_starve + 8'd1;
      end
      if (w_waw) begin
        err_waw <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_x_wb_arbiter.sv
// ============================================================================
// Module   : tb_x_wb_arbiter
// Purpose  : Self-checking bench for x_wb_arbiter. It uses a queue-based
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_x_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        stg_stall;
  logic        reg_w;
  logic [4:0]  rd;
  logic [31:0] w_data;
  logic [31:0] pend_mask;
  logic        err_waw;

  always #5 clk = ~clk;

  x_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .stg_stall(stg_stall), .reg_w(reg_w), .rd(rd), .w_data(w_data),
    .pend_mask(pend_mask), .err_waw(err_waw)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          starve = 0;
  logic        m_err  = 1'b0;
  logic        m_regw = 1'b0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m = m | (32'd1 << q[i].rd);
    return m;
  endfunction

  // One clock: drive, check the combinational outputs, advance the model,
  // then check the registered outputs after the edge.
  task automatic cycle(input logic i_r, input logic i_av, input logic [4:0] i_ard,
                       input logic [31:0] i_ad, input logic i_bv,
                       input logic [4:0] i_brd, input logic [31:0] i_bd);
    logic        ready, stall, popped, a_won;
    logic [31:0] mask;
    int          pre_size;
    ent_t        e;
    @(negedge clk);
    rst = i_r; a_valid = i_av; a_rd = i_ard; a_data = i_ad;
    b_valid = i_bv; b_rd = i_brd; b_data = i_bd;
    #1;
    pre_size = q.size();
    mask     = model_mask();
    ready    = !i_r && (pre_size < DEPTH);
    stall    = !i_r && (pre_size > 0) && (starve == LIMIT);
    check("b_ready", b_ready, ready);
    check("stg_stall", stg_stall, stall);
    check("pend_mask", pend_mask, mask);
    if (i_r) begin
      q.delete();
      starve = 0; m_err = 1'b0; m_regw = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      popped = 1'b0; a_won = 1'b0;
      if (stall || (!i_av && pre_size > 0)) begin
        e = q.pop_front();
        popped = 1'b1;
        m_regw = 1'b1; m_rd = e.rd; m_data = e.data;
      end else if (i_av) begin
        a_won  = 1'b1;
        m_regw = (i_ard != 5'd0);
        if (m_regw) begin m_rd = i_ard; m_data = i_ad; end
        if (i_ard != 5'd0 && mask[i_ard]) m_err = 1'b1;
      end else begin
        m_regw = 1'b0;
      end
      if (popped || pre_size == 0) starve = 0;
      else if (a_won && starve < LIMIT) starve++;
      if (i_bv && ready && i_brd != 5'd0) begin
        e.rd = i_brd; e.data = i_bd;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("reg_w", reg_w, m_regw);
    check("err_waw", err_waw, m_err);
    if (m_regw) begin
      check("rd", rd, m_rd);
      check("w_data", w_data, m_data);
    end
  endtask

  initial begin
    // Reset then idle
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("rst_rd", rd, 0);
    check("rst_wdata", w_data, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Port A alone, including a write to x0
    cycle(0, 1, 5, 32'h1234, 0, 0, 0);
    check("a5_rd", rd, 5);
    check("a5_data", w_data, 32'h1234);
    cycle(0, 1, 0, 32'h5555, 0, 0, 0);
    check("a0_regw", reg_w, 0);

    // Port B alone
    cycle(0, 0, 0, 0, 1, 3, 32'hAA);
    check("b3_pend", pend_mask, 32'h8);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("b3_rd", rd, 3);
    check("b3_data", w_data, 32'hAA);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Fill under port-A pressure, then starvation stall and the held A write
    for (int i = 0; i < 4; i++) cycle(0, 1, 5'(10 + i), 32'(i), 1, 5'(i + 1), 32'h100 + 32'(i));
    for (int i = 0; i < 14; i++) cycle(0, 1, 5'(20 + (i % 4)), 32'h200 + 32'(i), 1, 9, 32'hDEAD);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0, 0);

    // Streaming pushes with continuous pops, through pointer wrap
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 5'((i % 7) + 1), 32'h300 + 32'(i));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);

    // Full FIFO: a push in the same cycle as a pop is refused
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 32'(i), 1, 5'(i + 2), 32'h400 + 32'(i));
    cycle(0, 0, 0, 0, 1, 30, 32'hBEEF);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0);

    // WAW detection is sticky
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32'h1, 1, 7, 32'h77);
    cycle(0, 1, 7, 32'h7, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    check("waw_sticky", err_waw, 1);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) cycle(0, 1, 2, 32'(i), 1, 5'(i + 4), 32'h500 + 32'(i));
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    check("midrst_pend", pend_mask, 0);
    check("midrst_regw", reg_w, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic        r, av, bv;
      logic [4:0]  ard, brd;
      r   = ($urandom_range(0, 299) == 0);
      av  = ($urandom_range(0, 99) < 75);
      bv  = ($urandom_range(0, 99) < 50);
      ard = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      brd = 5'($urandom_range(0, 7));
      cycle(r, av, ard, $urandom, bv, brd, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/x_wb_arbiter.md
Name: x_wb_arbiter

Overview:
- Write-side front end of the scalar X register file.
- Merges two result sources into the file's single write port (reg_w / rd / w_data):
  - the scalar pipeline writeback (port A, priority);
  - scalar results returned by the vector unit, such as vmv.x.s and vector reductions (port B, valid/ready, buffered in a small FIFO).
- Exports a pending-write mask for hazard checking and a stall request that prevents starvation of port B.

Parameters:
- DEPTH, 4, port-B FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may lose to port A before stg_stall is forced; range 1..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  scalar pipeline write request; no backpressure except via stg_stall.
- a_rd  in  5  destination register for port A.
- a_data  in  32  write data for port A.
- b_valid  in  1  vector-unit result valid.
- b_ready  out  1  FIFO can accept; high when count < DEPTH.
- b_rd  in  5  destination register for port B.
- b_data  in  32  write data for port B.
- stg_stall  out  1  combinational; pipeline must hold and re-present port A next cycle.
- reg_w  out  1  registered write enable to the register file.
- rd  out  5  registered write address.
- w_data  out  32  registered write data.
- pend_mask  out  32  bit n high if any valid FIFO entry targets xn; bit 0 always 0.
- err_waw  out  1  sticky flag for a port-A write to a register pending in the FIFO.

Behaviour:
- Reset (rst=1 at a posedge):
  - reg_w=0, rd=0, w_data=0;
  - FIFO empty: wr_ptr=rd_ptr=0, count=0;
  - starve counter=0; err_waw=0.
  - Reset mid-operation discards all FIFO contents.
  - While rst is high, b_ready=0 and stg_stall=0.
- Port B push:
  - Occurs when b_valid && b_ready && !rst.
  - b_rd=0 is never stored; the request is dropped but the handshake completes.
- b_ready:
  - Depends only on count, never on b_valid or the same-cycle pop, so full with pop gives no pass-through.
- Per-cycle selection, with stg_stall = (count>0) && (starve==STARVE_LIMIT):
  - stg_stall=1: FIFO head wins and is popped; a_valid is ignored this cycle.
  - Otherwise, a_valid=1: port A wins.
  - Otherwise, count>0: FIFO head wins and is popped.
  - Otherwise: idle.
- Output register, one-cycle latency:
  - The winner is registered as reg_w=1, rd, w_data.
  - A port-A winner with a_rd=0 registers reg_w=0, and the slot is still consumed.
  - Idle registers reg_w=0; rd and w_data hold their previous values.
- Starve counter:
  - Resets to 0 on any pop or when count=0.
  - Increments when count>0 and port A wins.
  - Saturates at STARVE_LIMIT.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- Push into an empty FIFO: the entry becomes eligible the next cycle, not the same cycle.
- pend_mask:
  - Combinational OR of one-hot(rd) over valid FIFO entries.
  - Reflects post-edge FIFO state.
  - Duplicate rd entries keep the bit set until the last one pops.
- err_waw:
  - Set when port A wins with a_rd != 0 and pend_mask[a_rd]=1.
  - Cleared only by rst.
  - The block never reorders writes; issue logic is responsible for honouring pend_mask.
- Write ordering: port-B entries retire in push order.

Test Plan:
- Reset then idle: rst 1 cycle -> reg_w=0, rd=0, w_data=0, b_ready=1, pend_mask=0, err_waw=0.
- A alone: a_valid=1, a_rd=5, a_data=32'h1234 -> next cycle reg_w=1, rd=5, w_data=32'h1234; a_rd=0 -> reg_w=0.
- B alone: push b_rd=3, b_data=32'hAA -> pend_mask=32'h8 after the edge; one cycle later reg_w=1, rd=3, w_data=32'hAA; then pend_mask=0.
- Fill and backpressure:
  - Push 4 entries (rd 1..4) with a_valid held high -> b_ready=0 at count 4.
  - After 8 A-wins, stg_stall=1 for one cycle; rd=1 is written; starve counter resets.
  - The held port-A write is written the following cycle.
- Wrap and concurrency:
  - Stream 10 B pushes with a_valid=0 while popping every cycle -> in-order retirement through pointer wrap; count stays at most 1.
  - Push on a full FIFO in the same cycle as a pop is refused.
- WAW and mid-reset:
  - FIFO holds rd=7, then a_valid with a_rd=7 -> err_waw=1 and stays high.
  - rst with 3 entries queued -> FIFO empty, pend_mask=0, and no further writes from those entries.
